// File: rtl/memory_access_stage.sv
// MEM stage: byte/half/word loads and stores against a little-endian data memory,
// followed by the MEM/WB pipeline register and a combinational debug read port.
module memory_access_stage #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_stall,
  input  logic               i_halt,
  input  logic [NB_DATA-1:0] i_result,
  input  logic [NB_DATA-1:0] i_data4Mem,
  input  logic [1:0]         i_width,
  input  logic               i_sign_flag,
  input  logic               i_memRead,
  input  logic               i_memWrite,
  input  logic               i_mem2reg,
  input  logic               i_regWrite,
  input  logic [4:0]         i_write_reg,
  input  logic [NB_ADDR-3:0] i_dbg_addr,
  output logic [NB_DATA-1:0] o_read_data,
  output logic [NB_DATA-1:0] o_alu_result,
  output logic [NB_DATA-1:0] o_wb_data,
  output logic [4:0]         o_write_reg,
  output logic               o_regWrite,
  output logic               o_mem2reg,
  output logic               o_misaligned,
  output logic [NB_DATA-1:0] o_dbg_data
);

  localparam int DEPTH = 2 ** (NB_ADDR - 2);

  // There is no valid/ready handshake: every unfrozen cycle carries one instruction,
  // and freeze (i_stall | i_halt) holds the whole stage including the memory.
  logic [NB_DATA-1:0] mem [DEPTH];

  logic               freeze;
  logic               is_half;
  logic               is_word;
  logic               misaligned;
  logic               do_write;
  logic [NB_ADDR-3:0] word_idx;
  logic [1:0]         lane;
  logic [NB_DATA-1:0] rd_word;
  logic [NB_DATA-1:0] wr_word;
  logic [NB_DATA-1:0] load_data;
  logic [7:0]         rd_byte;
  logic [15:0]        rd_half;

  assign freeze   = i_stall | i_halt;
  assign word_idx = i_result[NB_ADDR-1:2];
  assign lane     = i_result[1:0];
  assign is_half  = (i_width == 2'b01);
  assign is_word  = i_width[1];

  assign misaligned = (i_memRead | i_memWrite) &
                      ((is_half & lane[0]) | (is_word & (lane != 2'b00)));
  assign do_write   = i_memWrite & ~misaligned & ~freeze;

  assign rd_word = mem[word_idx];
  assign rd_byte = rd_word[{lane, 3'b000} +: 8];
  assign rd_half = rd_word[{lane[1], 4'b0000} +: 16];

  always_comb begin
    load_data = '0;
    if (i_memRead && !misaligned) begin
      case (i_width)
        2'b00:   load_data = {{(NB_DATA-8){i_sign_flag & rd_byte[7]}}, rd_byte};
        2'b01:   load_data = {{(NB_DATA-16){i_sign_flag & rd_half[15]}}, rd_half};
        default: load_data = rd_word;
      endcase
    end
  end

  // Read-modify-write merge so unselected lanes keep their contents.
  always_comb begin
    wr_word = rd_word;
    case (i_width)
      2'b00:   wr_word[{lane, 3'b000} +: 8]     = i_data4Mem[7:0];
      2'b01:   wr_word[{lane[1], 4'b0000} +: 16] = i_data4Mem[15:0];
      default: wr_word = i_data4Mem;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_write) begin
      mem[word_idx] <= wr_word;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_read_data  <= '0;
      o_alu_result <= '0;
      o_write_reg  <= '0;
      o_regWrite   <= 1'b0;
      o_mem2reg    <= 1'b0;
      o_misaligned <= 1'b0;
    end else if (!freeze) begin
      o_read_data  <= load_data;
      o_alu_result <= i_result;
      o_write_reg  <= i_write_reg;
      o_regWrite   <= i_regWrite;
      o_mem2reg    <= i_mem2reg;
      o_misaligned <= misaligned;
    end
  end

  assign o_wb_data  = o_mem2reg ? o_read_data : o_alu_result;
  assign o_dbg_data = mem[i_dbg_addr];

endmodule

// File: tb/tb_memory_access_stage.sv
// Bench for memory_access_stage: byte-array reference model feeding an expected
// queue, a monitor that pops one entry per issued instruction, and directed checks.
module tb_memory_access_stage;

  logic        clk;
  logic        i_rst_n;
  logic        i_stall;
  logic        i_halt;
  logic [31:0] i_result;
  logic [31:0] i_data4Mem;
  logic [1:0]  i_width;
  logic        i_sign_flag;
  logic        i_memRead;
  logic        i_memWrite;
  logic        i_mem2reg;
  logic        i_regWrite;
  logic [4:0]  i_write_reg;
  logic [5:0]  i_dbg_addr;
  logic [31:0] o_read_data;
  logic [31:0] o_alu_result;
  logic [31:0] o_wb_data;
  logic [4:0]  o_write_reg;
  logic        o_regWrite;
  logic        o_mem2reg;
  logic        o_misaligned;
  logic [31:0] o_dbg_data;

  memory_access_stage #(.NB_DATA(32), .NB_ADDR(8)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_stall(i_stall), .i_halt(i_halt),
    .i_result(i_result), .i_data4Mem(i_data4Mem), .i_width(i_width),
    .i_sign_flag(i_sign_flag), .i_memRead(i_memRead), .i_memWrite(i_memWrite),
    .i_mem2reg(i_mem2reg), .i_regWrite(i_regWrite), .i_write_reg(i_write_reg),
    .i_dbg_addr(i_dbg_addr), .o_read_data(o_read_data), .o_alu_result(o_alu_result),
    .o_wb_data(o_wb_data), .o_write_reg(o_write_reg), .o_regWrite(o_regWrite),
    .o_mem2reg(o_mem2reg), .o_misaligned(o_misaligned), .o_dbg_data(o_dbg_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  // expected {read_data, alu_result, write_reg, regWrite, mem2reg, misaligned}
  logic [71:0] exp_q[$];

  // reference model state
  logic [7:0]  ref_mem [256];
  logic [31:0] exp_rd, exp_alu;
  logic [4:0]  exp_wreg;
  logic        exp_regw, exp_m2r, exp_mis;

  function automatic logic [31:0] model_word(input logic [5:0] idx);
    logic [7:0] b;
    b = {idx, 2'b00};
    return {ref_mem[b + 8'd3], ref_mem[b + 8'd2], ref_mem[b + 8'd1], ref_mem[b]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    exp_rd = '0; exp_alu = '0; exp_wreg = '0;
    exp_regw = 1'b0; exp_m2r = 1'b0; exp_mis = 1'b0;
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  // One instruction per call: driven at negedge, modelled, then the stage is
  // parked with i_stall=1 so idle clock edges change nothing.
  task automatic issue(input logic rd, input logic wr, input logic [1:0] w, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] data, input logic frz);
    logic [7:0]  a, base;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] ld;
    logic        mis;
    logic        regw;
    logic [4:0]  wreg;
    regw = 1'($urandom_range(0, 1));
    wreg = 5'($urandom_range(0, 31));
    @(negedge clk);
    i_memRead = rd; i_memWrite = wr; i_width = w; i_sign_flag = sgn;
    i_result = addr; i_data4Mem = data; i_mem2reg = rd;
    i_regWrite = regw; i_write_reg = wreg;
    i_halt = frz; i_stall = 1'b0;

    a   = addr[7:0];
    mis = (rd || wr) && ((w == 2'b01 && a[0]) || (w[1] && a[1:0] != 2'b00));
    if (!frz) begin
      ld = 32'h0;
      if (rd && !mis) begin
        if (w == 2'b00) begin
          b  = ref_mem[a];
          ld = {24'h0, b};
          if (sgn && b[7]) ld = ld | 32'hFFFF_FF00;
        end else if (w == 2'b01) begin
          base = {a[7:1], 1'b0};
          h    = {ref_mem[base + 8'd1], ref_mem[base]};
          ld   = {16'h0, h};
          if (sgn && h[15]) ld = ld | 32'hFFFF_0000;
        end else begin
          ld = model_word(a[7:2]);
        end
      end
      if (wr && !mis) begin
        if (w == 2'b00) begin
          ref_mem[a] = data[7:0];
        end else if (w == 2'b01) begin
          base = {a[7:1], 1'b0};
          ref_mem[base] = data[7:0];
          ref_mem[base + 8'd1] = data[15:8];
        end else begin
          base = {a[7:2], 2'b00};
          for (int k = 0; k < 4; k++) ref_mem[base + 8'(k)] = data[8*k +: 8];
        end
      end
      exp_rd = ld; exp_alu = addr; exp_wreg = wreg;
      exp_regw = regw; exp_m2r = rd; exp_mis = mis;
    end
    exp_q.push_back({exp_rd, exp_alu, exp_wreg, exp_regw, exp_m2r, exp_mis});
    @(posedge clk);
    #2;
    i_stall = 1'b1; i_halt = 1'b0;
  endtask

  task automatic check_dbg(input logic [5:0] idx, input logic [31:0] exp);
    i_dbg_addr = idx;
    #1;
    check_val($sformatf("dbg[%0d]", idx), o_dbg_data, exp);
  endtask

  // scoreboard monitor
  initial begin
    logic [71:0] e, g;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {o_read_data, o_alu_result, o_write_reg, o_regWrite, o_mem2reg, o_misaligned};
        n_checks++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL mem_wb_regs: got rd=%08h alu=%08h wr=%0d rw=%0b m2r=%0b mis=%0b expected rd=%08h alu=%08h wr=%0d rw=%0b m2r=%0b mis=%0b",
                   g[71:40], g[39:8], g[7:3], g[2], g[1], g[0],
                   e[71:40], e[39:8], e[7:3], e[2], e[1], e[0]);
        end
        check_val("wb_data", o_wb_data, e[1] ? e[71:40] : e[39:8]);
      end
    end
  end

  // main sequence
  initial begin
    i_rst_n = 1'b0; i_stall = 1'b1; i_halt = 1'b0;
    i_result = '0; i_data4Mem = '0; i_width = '0; i_sign_flag = 1'b0;
    i_memRead = 1'b0; i_memWrite = 1'b0; i_mem2reg = 1'b0; i_regWrite = 1'b0;
    i_write_reg = '0; i_dbg_addr = '0;
    model_reset();
    #12;
    check_val("rst_read_data", o_read_data, 32'h0);
    check_val("rst_alu_result", o_alu_result, 32'h0);
    check_val("rst_ctrl", {27'h0, o_write_reg, o_regWrite, o_mem2reg, o_misaligned}, 32'h0);
    check_dbg(6'd4, 32'h0);
    @(negedge clk);
    i_rst_n = 1'b1;

    // word store then load
    issue(1'b0, 1'b1, 2'b11, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
    issue(1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b0);
    check_val("lw_0x10", o_read_data, 32'hDEADBEEF);
    check_val("lw_0x10_wb", o_wb_data, 32'hDEADBEEF);
    check_dbg(6'd4, 32'hDEADBEEF);

    // byte lanes and extension
    issue(1'b0, 1'b1, 2'b11, 1'b0, 32'h20, 32'h80FF7F01, 1'b0);
    issue(1'b1, 1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 1'b0);
    check_val("lb_0x23", o_read_data, 32'hFFFFFF80);
    issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 1'b0);
    check_val("lbu_0x23", o_read_data, 32'h00000080);
    issue(1'b1, 1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 1'b0);
    check_val("lb_0x21", o_read_data, 32'h0000007F);
    issue(1'b1, 1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 1'b0);
    check_val("lh_0x22", o_read_data, 32'hFFFF80FF);
    issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 1'b0);
    check_val("lhu_0x20", o_read_data, 32'h00007F01);

    // partial stores
    issue(1'b0, 1'b1, 2'b11, 1'b0, 32'h30, 32'h11223344, 1'b0);
    issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h31, 32'h000000AA, 1'b0);
    issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h32, 32'h0000BEEF, 1'b0);
    issue(1'b1, 1'b0, 2'b11, 1'b0, 32'h30, 32'h0, 1'b0);
    check_val("lw_0x30", o_read_data, 32'hBEEFAA44);

    // misalignment
    issue(1'b0, 1'b1, 2'b11, 1'b0, 32'h41, 32'h12345678, 1'b0);
    check_val("sw_mis_flag", {31'h0, o_misaligned}, 32'h1);
    check_dbg(6'd16, 32'h0);
    issue(1'b1, 1'b0, 2'b01, 1'b1, 32'h43, 32'h0, 1'b0);
    check_val("lh_mis_data", o_read_data, 32'h0);
    check_val("lh_mis_flag", {31'h0, o_misaligned}, 32'h1);

    // read and write together return pre-write contents
    issue(1'b1, 1'b1, 2'b11, 1'b0, 32'h10, 32'hCAFEF00D, 1'b0);
    check_val("rw_same_cycle", o_read_data, 32'hDEADBEEF);
    check_dbg(6'd4, 32'hCAFEF00D);

    // halt for three cycles, then release
    for (int i = 0; i < 3; i++) issue(1'b0, 1'b1, 2'b11, 1'b0, 32'h08, 32'h5555AAAA, 1'b1);
    check_dbg(6'd2, 32'h0);
    check_val("halt_hold_alu", o_alu_result, 32'h10);
    issue(1'b0, 1'b1, 2'b11, 1'b0, 32'h08, 32'h5555AAAA, 1'b0);
    check_dbg(6'd2, 32'h5555AAAA);
    issue(1'b1, 1'b0, 2'b11, 1'b0, 32'h08, 32'h0, 1'b0);
    check_val("lw_0x08", o_read_data, 32'h5555AAAA);

    // randomized traffic, addresses wrap through the upper bits
    for (int n = 0; n < 400; n++) begin
      logic rd, wr;
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      issue(rd, wr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            {$urandom_range(0, 65535), 16'h0} | 32'($urandom_range(0, 255)),
            $urandom, ($urandom_range(0, 7) == 0));
      if (n % 8 == 0) begin
        logic [5:0] idx;
        idx = 6'($urandom_range(0, 63));
        check_dbg(idx, model_word(idx));
      end
    end

    // reset between clock edges
    issue(1'b0, 1'b1, 2'b11, 1'b0, 32'h04, 32'h01020304, 1'b0);
    issue(1'b1, 1'b0, 2'b11, 1'b1, 32'h04, 32'h0, 1'b0);
    @(posedge clk);
    #3;
    i_rst_n = 1'b0;
    model_reset();
    #1;
    check_val("midrst_read_data", o_read_data, 32'h0);
    check_val("midrst_alu_result", o_alu_result, 32'h0);
    check_val("midrst_wb_data", o_wb_data, 32'h0);
    check_val("midrst_ctrl", {27'h0, o_write_reg, o_regWrite, o_mem2reg, o_misaligned}, 32'h0);
    for (int i = 0; i < 64; i++) check_dbg(6'(i), 32'h0);
    @(negedge clk);
    i_rst_n = 1'b1;
    issue(1'b1, 1'b0, 2'b11, 1'b0, 32'h04, 32'h0, 1'b0);
    check_val("lw_after_rst", o_read_data, 32'h0);

    repeat (3) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
